// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (data over fetch) arbiter onto one shared memory port with wait timeout.
// Optional statistics counter enabled by defining ARB_STATS_EN.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_data,
    output logic        if_ack,
    input  logic        d_ren,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_dout,
    input  logic [31:0] mem_din,
    input  logic        mem_ack,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        bus_err,
    output logic [15:0] conflict_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic       busy;
    logic       timed_out;
    logic       done;
    logic       arb_ok;
    logic       d_req;
    logic       d_pend;
    logic       i_pend;
    logic       grant_d;
    logic       grant_i;

    // A completing port is masked both on its finishing edge and in its ack
    // cycle, so the other port can be granted back-to-back without duplicates.
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        d_req      = d_ren | d_wen;
        timed_out  = busy & ~mem_ack & (wait_cnt == WAIT_LAST);
        done       = busy & (mem_ack | timed_out);
        d_pend     = d_req & ~d_ack & (state != BUSY_D);
        i_pend     = if_req & ~if_ack & (state != BUSY_I);
        arb_ok     = (state == IDLE) | done;
        grant_d    = arb_ok & cpu_en & d_pend;
        grant_i    = arb_ok & cpu_en & i_pend & ~d_pend;
        if (grant_d) begin
            state_next = BUSY_D;
        end else if (grant_i) begin
            state_next = BUSY_I;
        end else if (done) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we   <= 1'b0;
            mem_addr <= 32'h0;
            mem_dout <= 32'h0;
            if_data  <= 32'h0;
            d_rdata  <= 32'h0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            bus_err  <= 1'b0;
            wait_cnt <= 8'h0;
        end else begin
            d_ack  <= done & (state == BUSY_D);
            if_ack <= done & (state == BUSY_I);
            if (done && state == BUSY_D && !mem_we) begin
                d_rdata <= mem_ack ? mem_din : 32'hFFFF_FFFF;
            end
            if (done && state == BUSY_I) begin
                if_data <= mem_ack ? mem_din : 32'hFFFF_FFFF;
            end
            if (timed_out) begin
                bus_err <= 1'b1;
            end
            if (grant_d) begin
                mem_addr <= d_addr;
                mem_we   <= d_wen;
                if (d_wen) begin
                    mem_dout <= d_wdata;
                end
                wait_cnt <= 8'h0;
            end else if (grant_i) begin
                mem_addr <= if_addr;
                mem_we   <= 1'b0;
                wait_cnt <= 8'h0;
            end else begin
                if (done) begin
                    mem_we <= 1'b0;
                end
                if (busy && !mem_ack) begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] conflict_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_q <= 16'h0;
        end else if ((grant_d | grant_i) && d_pend && i_pend && conflict_q != 16'hFFFF) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = 16'h0;
`endif

    assign mem_cs    = (state != IDLE);
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = (d_ren | d_wen) & ~d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_ack;
    logic        d_ren;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        bus_err;
    logic [15:0] conflict_cnt;

    int total = 0;
    int bad = 0;
    logic [31:0] if_q[$];
    logic [31:0] d_q[$];

`ifdef ARB_STATS_EN
    localparam logic [15:0] CONFLICT_EXP = 16'd1;
`else
    localparam logic [15:0] CONFLICT_EXP = 16'd0;
`endif

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .cpu_en(cpu_en),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_ack(if_ack),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .mem_din(mem_din), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic pop_d(input string tag);
        if (d_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            chk(tag, d_rdata, d_q.pop_front());
        end
    endtask

    task automatic pop_if(input string tag);
        if (if_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            chk(tag, if_data, if_q.pop_front());
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b0; cpu_en = 1'b0; if_req = 1'b0; if_addr = 32'h0;
        d_ren = 1'b0; d_wen = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        mem_din = 32'h0; mem_ack = 1'b0;
        tick(3);
        chk1("rst_mem_cs", mem_cs, 1'b0);
        chk1("rst_bus_err", bus_err, 1'b0);
        chk("rst_conflict", {16'h0, conflict_cnt}, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        #2 rst = 1'b1;
        tick(1);

        // single fetch, zero-wait memory
        cpu_en = 1'b1; if_req = 1'b1; if_addr = 32'h0000_0040;
        mem_ack = 1'b1; mem_din = 32'h2008_0005;
        if_q.push_back(32'h2008_0005);
        #1;
        chk1("f_c0_stall_if", stall_if, 1'b1);
        chk1("f_c0_mem_cs", mem_cs, 1'b0);
        tick(1);
        chk1("f_c1_mem_cs", mem_cs, 1'b1);
        chk("f_c1_mem_addr", mem_addr, 32'h0000_0040);
        chk1("f_c1_stall_if", stall_if, 1'b1);
        chk1("f_c1_if_ack", if_ack, 1'b0);
        tick(1);
        chk1("f_c2_if_ack", if_ack, 1'b1);
        pop_if("f_c2_if_data");
        chk1("f_c2_stall_if", stall_if, 1'b0);
        chk1("f_c2_no_regrant", mem_cs, 1'b0);
        if_req = 1'b0;
        tick(1);
        chk1("f_c3_if_ack", if_ack, 1'b0);

        // simultaneous write and fetch: write wins, fetch follows back-to-back
        d_wen = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 32'h80; mem_din = 32'h1111_2222;
        if_q.push_back(32'h1111_2222);
        tick(1);
        chk1("c_c1_mem_cs", mem_cs, 1'b1);
        chk1("c_c1_mem_we", mem_we, 1'b1);
        chk("c_c1_mem_addr", mem_addr, 32'h100);
        chk("c_c1_mem_dout", mem_dout, 32'hDEAD_BEEF);
        chk1("c_c1_stall_mem", stall_mem, 1'b1);
        tick(1);
        chk1("c_c2_d_ack", d_ack, 1'b1);
        chk1("c_c2_fetch_cs", mem_cs, 1'b1);
        chk1("c_c2_fetch_we", mem_we, 1'b0);
        chk("c_c2_fetch_addr", mem_addr, 32'h80);
        chk("c_c2_d_rdata_kept", d_rdata, 32'h0);
        chk1("c_c2_stall_mem", stall_mem, 1'b0);
        d_wen = 1'b0;
        tick(1);
        chk1("c_c3_if_ack", if_ack, 1'b1);
        pop_if("c_c3_if_data");
        chk1("c_c3_d_ack", d_ack, 1'b0);
        chk("c_c3_conflict", {16'h0, conflict_cnt}, {16'h0, CONFLICT_EXP});
        if_req = 1'b0;
        tick(1);

        // cpu_en dropped during a fetch while a data read waits
        if_req = 1'b1; if_addr = 32'hC0; mem_ack = 1'b0;
        tick(1);
        chk1("e_c1_fetch_cs", mem_cs, 1'b1);
        cpu_en = 1'b0; d_ren = 1'b1; d_addr = 32'h200;
        mem_ack = 1'b1; mem_din = 32'h3333_4444;
        if_q.push_back(32'h3333_4444);
        tick(1);
        chk1("e_c2_if_ack", if_ack, 1'b1);
        pop_if("e_c2_if_data");
        chk1("e_c2_no_grant", mem_cs, 1'b0);
        if_req = 1'b0;
        tick(2);
        chk1("e_c4_no_grant", mem_cs, 1'b0);
        chk1("e_c4_stall_mem", stall_mem, 1'b1);
        cpu_en = 1'b1; mem_din = 32'h5555_6666;
        d_q.push_back(32'h5555_6666);
        #1;
        chk1("e_en_same_cycle", mem_cs, 1'b0);
        tick(1);
        chk1("e_grant_cs", mem_cs, 1'b1);
        chk("e_grant_addr", mem_addr, 32'h200);
        tick(1);
        chk1("e_d_ack", d_ack, 1'b1);
        pop_d("e_d_rdata");
        d_ren = 1'b0;
        tick(1);

        // read timeout with TIMEOUT=4
        d_ren = 1'b1; d_addr = 32'h300; mem_ack = 1'b0;
        d_q.push_back(32'hFFFF_FFFF);
        tick(4);
        chk1("t_c4_mem_cs", mem_cs, 1'b1);
        chk1("t_c4_d_ack", d_ack, 1'b0);
        chk1("t_c4_bus_err", bus_err, 1'b0);
        tick(1);
        chk1("t_c5_d_ack", d_ack, 1'b1);
        pop_d("t_c5_d_rdata");
        chk1("t_c5_bus_err", bus_err, 1'b1);
        d_ren = 1'b0;
        tick(10);
        chk1("t_sticky_bus_err", bus_err, 1'b1);
        chk1("t_idle_cs", mem_cs, 1'b0);

        // asynchronous reset during BUSY_D
        d_ren = 1'b1; d_addr = 32'h400;
        tick(1);
        chk1("r_busy_cs", mem_cs, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk1("r_async_cs", mem_cs, 1'b0);
        chk1("r_bus_err", bus_err, 1'b0);
        chk("r_conflict", {16'h0, conflict_cnt}, 32'h0);
        d_ren = 1'b0; mem_ack = 1'b1;
        #1 rst = 1'b1;
        tick(1);
        chk1("r_no_d_ack_1", d_ack, 1'b0);
        chk1("r_idle_cs", mem_cs, 1'b0);
        tick(1);
        chk1("r_no_d_ack_2", d_ack, 1'b0);

        chk("queues_drained", if_q.size() + d_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
